glb_fifo_xfer_ctrl: RTL

GLB_FIFO_XFER_CTRL -- requirements
Module: glb_fifo_xfer_ctrl

---
 rtl/glb_fifo_xfer_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/glb_fifo_xfer_ctrl.sv
// Multi-channel FIFO <-> GLB transfer controller: per-channel task FSMs share one
// GLB port through a round-robin arbiter. Fill = GLB->FIFO reads, drain = FIFO->GLB writes.

module glb_fifo_xfer_ch #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  len,
  input  logic              full,
  input  logic              empty,
  input  logic              acc,
  output logic              elig,
  output logic              dir_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic              out_q,
  output logic              done,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic             out_nxt;

  assign rem_nxt = acc ? rem_q - CNT_W'(1) : rem_q;
  assign out_nxt = acc & ~dir_q;

  // Fill completes only once the last read's data has been pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      out_q   <= 1'b0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      out_q <= out_nxt;
      unique case (state_q)
        IDLE: if (start) begin
          dir_q   <= dir;
          addr_q  <= base;
          rem_q   <= len;
          state_q <= (len == '0) ? DONE : ACTIVE;
        end
        ACTIVE: begin
          rem_q <= rem_nxt;
          if (acc) addr_q <= addr_q + ADDR_W'(4);
          if (rem_nxt == '0 && !out_nxt) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign elig = (state_q == ACTIVE) && (rem_q != '0) &&
                (dir_q ? ~empty : (~full & ~out_q));
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);
endmodule

module glb_fifo_xfer_ctrl #(
  parameter int NUM_CH = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              start_i,
  input  logic [NUM_CH-1:0]              dir_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  base_addr_i,
  input  logic [NUM_CH-1:0][CNT_W-1:0]   len_i,
  input  logic [NUM_CH-1:0]              fifo_full_i,
  input  logic [NUM_CH-1:0]              fifo_empty_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  fifo_pop_data_i,
  output logic [NUM_CH-1:0]              fifo_push_o,
  output logic [DATA_W-1:0]              fifo_push_data_o,
  output logic [NUM_CH-1:0]              fifo_pop_o,
  output logic                           glb_req_o,
  output logic                           glb_we_o,
  output logic [ADDR_W-1:0]              glb_addr_o,
  output logic [DATA_W-1:0]              glb_wdata_o,
  input  logic                           glb_ready_i,
  input  logic [DATA_W-1:0]              glb_rdata_i,
  output logic [NUM_CH-1:0]              done_o,
  output logic [NUM_CH-1:0]              busy_o,
  output logic                           any_busy_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW   = CH_W + 1;

  logic [NUM_CH-1:0]             elig, dir_q, out_q, acc;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_q;
  logic [CH_W-1:0]               ptr_q, hold_ch_q, gnt;
  logic                          hold_q, gnt_vld, accept;
  logic [IW-1:0]                 idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    glb_fifo_xfer_ch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .start (start_i[c]),
      .dir   (dir_i[c]),
      .base  (base_addr_i[c]),
      .len   (len_i[c]),
      .full  (fifo_full_i[c]),
      .empty (fifo_empty_i[c]),
      .acc   (acc[c]),
      .elig  (elig[c]),
      .dir_q (dir_q[c]),
      .addr_q(addr_q[c]),
      .out_q (out_q[c]),
      .done  (done_o[c]),
      .busy  (busy_o[c])
    );
  end

  // A stalled request keeps its grant so address/we/wdata cannot shift under the GLB.
  always_comb begin
    gnt_vld = hold_q;
    gnt     = hold_ch_q;
    idx     = '0;
    if (!hold_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx = {1'b0, ptr_q} + IW'(i);
        if (idx >= IW'(NUM_CH)) idx = idx - IW'(NUM_CH);
        if (!gnt_vld && elig[idx[CH_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt     = idx[CH_W-1:0];
        end
      end
    end
  end

  assign accept = gnt_vld & glb_ready_i;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) acc[c] = accept && (gnt == CH_W'(c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
    end else begin
      hold_q    <= gnt_vld & ~glb_ready_i;
      hold_ch_q <= gnt;
      if (accept) ptr_q <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
    end
  end

  // Reset drops an in-flight read: its push is masked in the reset cycle itself.
  assign fifo_push_o      = out_q & {NUM_CH{~rst}};
  assign fifo_push_data_o = (|fifo_push_o) ? glb_rdata_i : '0;
  assign fifo_pop_o       = acc & dir_q;
  assign glb_req_o        = gnt_vld;
  assign glb_we_o         = gnt_vld & dir_q[gnt];
  assign glb_addr_o       = gnt_vld ? addr_q[gnt] : '0;
  assign glb_wdata_o      = glb_we_o ? fifo_pop_data_i[gnt] : '0;
  assign any_busy_o       = |busy_o;
endmodule
